// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC and talks to a variable-latency instruction memory. It takes
// redirects back from decode, and loads bubbles into IF/ID while a fetch is
// outstanding or a redirect is being resolved.
// Optional feature: define IF_SKID_BUF_EN to add a one-entry skid buffer.
// The buffer captures a word that returns while the pipeline is stalled, so
// that word does not have to be fetched again.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [1:0]  PCsrc_i,
  input  logic [31:0] pcPlusImm_i,
  input  logic [31:0] regPlusImm_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] PC_o,
  output logic [31:0] pcPlus4_o,
  output logic [24:0] Instr31_7_o,
  output logic [6:0]  op_o,
  output logic [4:0]  rd_o,
  output logic [2:0]  funct3_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic        funct7_5_o,
  output logic        fetchBubble_o
);

  // FETCH: a request is outstanding at pc_q.
  // DRAIN: a redirect arrived during a miss. The stale request must finish
  // before the target address can go out, so that imem_addr_o stays stable.
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] redir_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_pc4_q;
  logic [31:0] ifid_instr_q;
  logic        bubble_q;

  logic        redirect_d;
  logic [31:0] redir_src_d;
  logic [31:0] target_d;
  logic        word_avail_d;
  logic [31:0] word_d;
  logic [31:0] word_pc_d;
  logic [31:0] word_pc4_d;

  // Decode asks for a redirect only when the pipeline advances.
  // Select 11 is treated the same as 00, which means sequential fetch.
  assign redirect_d  = en_i && ((PCsrc_i == 2'b01) || (PCsrc_i == 2'b10));
  assign redir_src_d = (PCsrc_i == 2'b01) ? pcPlusImm_i : regPlusImm_i;
  assign target_d    = redir_src_d & ~32'h0000_0003;

`ifdef IF_SKID_BUF_EN
  logic        buf_v_q;
  logic [31:0] buf_pc_q;
  logic [31:0] buf_instr_q;

  // A buffered word takes the place of a memory return. No new request is
  // issued while the buffer holds a word.
  assign word_avail_d = buf_v_q || imem_ready_i;
  assign word_d       = buf_v_q ? buf_instr_q : imem_rdata_i;
  assign word_pc_d    = buf_v_q ? buf_pc_q : pc_q;
  assign imem_req_o   = !buf_v_q;
`else
  // There is no buffer, so only the memory can supply a word. A request is
  // outstanding in both states.
  assign word_avail_d = imem_ready_i;
  assign word_d       = imem_rdata_i;
  assign word_pc_d    = pc_q;
  assign imem_req_o   = 1'b1;
`endif

  assign word_pc4_d  = word_pc_d + 32'd4;
  assign imem_addr_o = pc_q;

  // All IF/ID fields are plain slices of the registered instruction word.
  assign PC_o          = ifid_pc_q;
  assign pcPlus4_o     = ifid_pc4_q;
  assign Instr31_7_o   = ifid_instr_q[31:7];
  assign op_o          = ifid_instr_q[6:0];
  assign rd_o          = ifid_instr_q[11:7];
  assign funct3_o      = ifid_instr_q[14:12];
  assign rs1_o         = ifid_instr_q[19:15];
  assign rs2_o         = ifid_instr_q[24:20];
  assign funct7_5_o    = ifid_instr_q[30];
  assign fetchBubble_o = bubble_q;

  // Fetch state machine, PC, redirect holding register and IF/ID register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      redir_q      <= 32'h0000_0000;
      ifid_pc_q    <= 32'h0000_0000;
      ifid_pc4_q   <= 32'h0000_0000;
      ifid_instr_q <= NOP_INSTR;
      bubble_q     <= 1'b1;
`ifdef IF_SKID_BUF_EN
      buf_v_q      <= 1'b0;
      buf_pc_q     <= 32'h0000_0000;
      buf_instr_q  <= 32'h0000_0000;
`endif
    end else if (en_i) begin
      case (state_q)
        FETCH: begin
`ifdef IF_SKID_BUF_EN
          // If the buffer holds a word, that word is consumed (or dropped on a
          // redirect) in this cycle.
          buf_v_q <= 1'b0;
`endif
          if (word_avail_d && !redirect_d) begin
            ifid_pc_q    <= word_pc_d;
            ifid_pc4_q   <= word_pc4_d;
            ifid_instr_q <= word_d;
            bubble_q     <= 1'b0;
            pc_q         <= word_pc4_d;
          end else begin
            ifid_instr_q <= NOP_INSTR;
            bubble_q     <= 1'b1;
            if (word_avail_d) begin
              // The word is from the wrong path, so it is dropped.
              pc_q <= target_d;
            end else if (redirect_d) begin
              // A miss is still in flight. Keep the target until it completes.
              redir_q <= target_d;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Decode sees only bubbles here, so PCsrc_i cannot matter.
          ifid_instr_q <= NOP_INSTR;
          bubble_q     <= 1'b1;
          if (imem_ready_i) begin
            pc_q    <= redir_q;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end else begin
`ifdef IF_SKID_BUF_EN
      // A word that returns during a stall is kept so it is not fetched again.
      if ((state_q == FETCH) && imem_ready_i && !buf_v_q) begin
        buf_v_q     <= 1'b1;
        buf_pc_q    <= pc_q;
        buf_instr_q <= imem_rdata_i;
      end
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: randomized scoreboard bench for if_fetch_stage.
// The instruction memory returns a hash of the address.
// A reference model of the fetch rules predicts IF/ID and the request
// outputs after every clock. A monitor compares them.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_i, en_i, imem_ready_i;
  logic [1:0]  PCsrc_i;
  logic [31:0] pcPlusImm_i, regPlusImm_i, imem_rdata_i;
  logic        imem_req_o, funct7_5_o, fetchBubble_o;
  logic [31:0] imem_addr_o, PC_o, pcPlus4_o;
  logic [24:0] Instr31_7_o;
  logic [6:0]  op_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [2:0]  funct3_o;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  assign imem_rdata_i = mem_word(imem_addr_o);

  if_fetch_stage dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .PCsrc_i(PCsrc_i),
    .pcPlusImm_i(pcPlusImm_i), .regPlusImm_i(regPlusImm_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
    .PC_o(PC_o), .pcPlus4_o(pcPlus4_o), .Instr31_7_o(Instr31_7_o),
    .op_o(op_o), .rd_o(rd_o), .funct3_o(funct3_o), .rs1_o(rs1_o),
    .rs2_o(rs2_o), .funct7_5_o(funct7_5_o), .fetchBubble_o(fetchBubble_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        bub;
    logic        req;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic [31:0] m_pc, m_tgt, m_buf_instr;
  logic [31:0] m_ifid_pc, m_ifid_pc4, m_ifid_instr;
  logic        m_bub, m_waiting, m_buf_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, advance the model, and queue the expectation.
  task automatic apply(input logic rst, input logic en, input logic [1:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic rdy);
    exp_t e;
    logic        red, have;
    logic [31:0] tgt, word;
    rst_i = rst; en_i = en; PCsrc_i = sel;
    pcPlusImm_i = a; regPlusImm_i = b; imem_ready_i = rdy;
    if (rst) begin
      m_pc = 32'h0; m_tgt = 32'h0; m_waiting = 1'b0; m_buf_v = 1'b0;
      m_ifid_pc = 32'h0; m_ifid_pc4 = 32'h0; m_ifid_instr = 32'h13; m_bub = 1'b1;
    end else if (!en) begin
`ifdef IF_SKID_BUF_EN
      if (!m_waiting && !m_buf_v && rdy) begin
        m_buf_v = 1'b1;
        m_buf_instr = mem_word(m_pc);
      end
`endif
    end else if (m_waiting) begin
      m_ifid_instr = 32'h13; m_bub = 1'b1;
      if (rdy) begin
        m_waiting = 1'b0;
        m_pc = m_tgt;
      end
    end else begin
      red  = (sel == 2'd1) || (sel == 2'd2);
      tgt  = ((sel == 2'd1) ? a : b) & 32'hFFFF_FFFC;
      have = m_buf_v || rdy;
      word = m_buf_v ? m_buf_instr : mem_word(m_pc);
      m_buf_v = 1'b0;
      if (have && !red) begin
        m_ifid_pc = m_pc; m_ifid_pc4 = m_pc + 32'd4;
        m_ifid_instr = word; m_bub = 1'b0;
        m_pc = m_pc + 32'd4;
      end else begin
        m_ifid_instr = 32'h13; m_bub = 1'b1;
        if (have) m_pc = tgt;
        else if (red) begin
          m_waiting = 1'b1;
          m_tgt = tgt;
        end
      end
    end
    e.pc = m_ifid_pc; e.pc4 = m_ifid_pc4; e.instr = m_ifid_instr;
    e.bub = m_bub; e.addr = m_pc;
`ifdef IF_SKID_BUF_EN
    e.req = !m_buf_v;
`else
    e.req = 1'b1;
`endif
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: after every clock edge, pop one expectation and compare.
  initial begin
    exp_t e;
    logic [31:0] ins;
    forever begin
      @(posedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        ins = e.instr;
        $display("t=%0t pc=%h instr=%h bub=%0b addr=%h req=%0b",
                 $time, PC_o, {Instr31_7_o, op_o}, fetchBubble_o, imem_addr_o, imem_req_o);
        chk("PC_o", PC_o, e.pc);
        chk("pcPlus4_o", pcPlus4_o, e.pc4);
        chk("instr", {Instr31_7_o, op_o}, ins);
        chk("rd_o", {27'd0, rd_o}, {27'd0, ins[11:7]});
        chk("funct3_o", {29'd0, funct3_o}, {29'd0, ins[14:12]});
        chk("rs1_o", {27'd0, rs1_o}, {27'd0, ins[19:15]});
        chk("rs2_o", {27'd0, rs2_o}, {27'd0, ins[24:20]});
        chk("funct7_5_o", {31'd0, funct7_5_o}, {31'd0, ins[30]});
        chk("fetchBubble_o", {31'd0, fetchBubble_o}, {31'd0, e.bub});
        chk("imem_addr_o", imem_addr_o, e.addr);
        chk("imem_req_o", {31'd0, imem_req_o}, {31'd0, e.req});
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized phases.
  initial begin
    int p_rdy[6] = '{100, 70, 30, 90, 50, 10};
    int p_en[6]  = '{100, 80, 60, 95, 70, 90};
    logic [31:0] a, b;
    logic [1:0]  sel;
    logic        rdy, en, rst;
    #1;
    apply(1, 1, 0, 0, 0, 1);
    apply(1, 1, 0, 0, 0, 1);
    repeat (2) apply(0, 1, 0, 0, 0, 1);
    repeat (3) apply(0, 1, 0, 0, 0, 0);
    repeat (3) apply(0, 1, 0, 0, 0, 1);
    apply(0, 1, 2'd1, 32'h40, 0, 1);
    repeat (2) apply(0, 1, 0, 0, 0, 1);
    apply(0, 1, 2'd2, 0, 32'h83, 0);
    apply(0, 1, 2'd1, 32'h500, 0, 0);
    apply(0, 1, 0, 0, 0, 1);
    repeat (2) apply(0, 1, 0, 0, 0, 1);
    repeat (2) apply(0, 0, 2'd1, 32'h700, 0, 1);
    repeat (2) apply(0, 1, 0, 0, 0, 1);
    apply(0, 1, 2'd1, 32'hFFFF_FFF8, 0, 1);
    repeat (3) apply(0, 1, 0, 0, 0, 1);
    repeat (2) apply(0, 1, 2'd3, 32'h900, 32'h904, 1);
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 400; c++) begin
        rst = ($urandom_range(0, 199) == 0);
        en  = ($urandom_range(1, 100) <= p_en[ph]);
        rdy = ($urandom_range(1, 100) <= p_rdy[ph]);
        sel = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 3) & 3);
        if (sel == 2'd1 || sel == 2'd2) sel = sel;
        else if (sel != 2'd3) sel = 2'd0;
        a = $urandom;
        b = $urandom;
        if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        apply(rst, en, sel, a, b, rdy);
      end
    end
    repeat (2) @(posedge clk);
    #5;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
